// File: rtl/sd_seq_pkg.sv
// Shared types and constants for the SD sector sequencer: FSM states,
// error codes and the sector-to-card-address mapping.
package sd_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    ISSUE,
    XFER_RD,
    XFER_WR,
    DONE
  } seq_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_SHORT   = 2'd2;

  localparam int unsigned SECTOR_BYTES_DEFAULT = 512;
  localparam int          BUF_ADDR_W           = 9;

  // Standard-capacity cards take a byte address; SDHC cards take the block number.
  function automatic logic [31:0] sector_to_address(input logic [31:0] sector, input bit sdhc);
    return sdhc ? sector : {sector[22:0], 9'd0};
  endfunction

endpackage

// File: rtl/sd_edge_det.sv
// Registers a level input once and flags rising/falling transitions of the
// live input against that registered copy.
module sd_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_reg;

  always_ff @(posedge clk) begin
    if (reset) level_reg <= 1'b0;
    else       level_reg <= level;
  end

  assign rise = level & ~level_reg;
  assign fall = ~level & level_reg;

endmodule

// File: rtl/sd_sector_sequencer.sv
// Drives sd_controller through one whole-sector read or write and streams the
// bytes to/from an external sector buffer, reporting done/err at the end.
module sd_sector_sequencer
  import sd_seq_pkg::*;
#(
  parameter bit          SDHC           = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned SECTOR_BYTES   = SECTOR_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_sector,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [8:0]  buf_addr,
  output logic        buf_we,
  output logic [7:0]  buf_wdata,
  input  logic [7:0]  buf_rdata,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_address,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  input  logic        sd_ready_for_next_byte,
  input  logic        sd_ready
);

  localparam int               CNT_W      = $clog2(SECTOR_BYTES + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(SECTOR_BYTES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [31:0]      TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  seq_state_t       state_reg;
  logic             write_reg;
  logic [CNT_W-1:0] count_reg;
  logic [31:0]      tmo_reg;

  logic [1:0] level_in;
  logic [1:0] rise;
  logic [1:0] fall;
  logic       byte_rise;
  logic       rfnb_fall;
  logic       unused_edges;
  logic       xfer_full;
  logic       tmo_hit;

  // Bit 0: byte_available, bit 1: ready_for_next_byte.
  assign level_in = {sd_ready_for_next_byte, sd_byte_available};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_edge
      sd_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .level (level_in[gi]),
        .rise  (rise[gi]),
        .fall  (fall[gi])
      );
    end
  endgenerate

  assign byte_rise    = rise[0];
  assign rfnb_fall    = fall[1];
  assign unused_edges = rise[1] | fall[0];
  assign xfer_full    = (count_reg == FULL_COUNT);
  assign tmo_hit      = (tmo_reg >= TMO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      write_reg  <= 1'b0;
      count_reg  <= '0;
      tmo_reg    <= '0;
      cmd_ready  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      buf_addr   <= '0;
      buf_we     <= 1'b0;
      buf_wdata  <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      sd_address <= '0;
      sd_din     <= '0;
    end else begin
      buf_we <= 1'b0;
      done   <= 1'b0;

      // Buffer read data trails buf_addr by one cycle; keep sd_din tracking it
      // so byte[count] is in place well before the controller samples it.
      if (write_reg && (state_reg == WAIT_READY || state_reg == ISSUE || state_reg == XFER_WR))
        sd_din <= buf_rdata;

      case (state_reg)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            write_reg  <= cmd_write;
            sd_address <= sector_to_address(cmd_sector, SDHC);
            count_reg  <= '0;
            tmo_reg    <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            buf_addr   <= '0;
            cmd_ready  <= 1'b0;
            state_reg  <= WAIT_READY;
          end
        end

        WAIT_READY: begin
          if (tmo_hit) begin
            err_code  <= ERR_TIMEOUT;
            err       <= 1'b1;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (sd_ready) begin
            sd_rd     <= ~write_reg;
            sd_wr     <= write_reg;
            tmo_reg   <= '0;
            state_reg <= ISSUE;
          end else begin
            tmo_reg <= tmo_reg + 32'd1;
          end
        end

        ISSUE: begin
          if (tmo_hit) begin
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            err_code  <= ERR_TIMEOUT;
            err       <= 1'b1;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (!sd_ready) begin
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            tmo_reg   <= '0;
            state_reg <= write_reg ? XFER_WR : XFER_RD;
          end else begin
            tmo_reg <= tmo_reg + 32'd1;
          end
        end

        XFER_RD, XFER_WR: begin
          if (sd_ready) begin
            err_code  <= xfer_full ? ERR_NONE : ERR_SHORT;
            err       <= ~xfer_full;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (tmo_hit) begin
            err_code  <= ERR_TIMEOUT;
            err       <= 1'b1;
            done      <= 1'b1;
            state_reg <= DONE;
          end else if (state_reg == XFER_RD && byte_rise && !xfer_full) begin
            buf_we    <= 1'b1;
            buf_addr  <= BUF_ADDR_W'(count_reg);
            buf_wdata <= sd_dout;
            count_reg <= count_reg + CNT_ONE;
            tmo_reg   <= '0;
          end else if (state_reg == XFER_WR && rfnb_fall && !xfer_full) begin
            count_reg <= count_reg + CNT_ONE;
            // Past the last byte the address stays put so sd_din keeps its value.
            if (count_reg < FULL_COUNT - CNT_ONE)
              buf_addr <= BUF_ADDR_W'(count_reg + CNT_ONE);
            tmo_reg <= '0;
          end else begin
            tmo_reg <= tmo_reg + 32'd1;
          end
        end

        DONE: begin
          err       <= 1'b0;
          cmd_ready <= 1'b1;
          state_reg <= IDLE;
        end

        default: begin
          cmd_ready <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_sequencer.sv
// Randomized bench for sd_sector_sequencer: a behavioural sd_controller and
// sector-buffer model, with expectations computed from sector/byte arithmetic.
module tb_sd_sector_sequencer;

  localparam int TMO = 1000;
  localparam int SB  = 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_sector;
  logic        done, err;
  logic [1:0]  err_code;
  logic [8:0]  buf_addr;
  logic        buf_we;
  logic [7:0]  buf_wdata, buf_rdata;
  logic        sd_rd, sd_wr;
  logic [31:0] sd_address;
  logic [7:0]  sd_din, sd_dout;
  logic        sd_byte_available, sd_ready_for_next_byte, sd_ready;

  // Second instance in block-addressing mode; only its address is observed.
  logic        cmd_ready_b, done_b, err_b, buf_we_b, sd_rd_b, sd_wr_b;
  logic [1:0]  err_code_b;
  logic [8:0]  buf_addr_b;
  logic [7:0]  buf_wdata_b, sd_din_b;
  logic [31:0] sd_address_b;

  always #5 clk = ~clk;

  sd_sector_sequencer #(.SDHC(1'b0), .TIMEOUT_CYCLES(TMO), .SECTOR_BYTES(SB)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_sector(cmd_sector),
    .done(done), .err(err), .err_code(err_code),
    .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_address(sd_address), .sd_din(sd_din), .sd_dout(sd_dout),
    .sd_byte_available(sd_byte_available), .sd_ready_for_next_byte(sd_ready_for_next_byte),
    .sd_ready(sd_ready)
  );

  sd_sector_sequencer #(.SDHC(1'b1), .TIMEOUT_CYCLES(TMO), .SECTOR_BYTES(SB)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write), .cmd_sector(cmd_sector),
    .done(done_b), .err(err_b), .err_code(err_code_b),
    .buf_addr(buf_addr_b), .buf_we(buf_we_b), .buf_wdata(buf_wdata_b), .buf_rdata(8'h00),
    .sd_rd(sd_rd_b), .sd_wr(sd_wr_b), .sd_address(sd_address_b), .sd_din(sd_din_b), .sd_dout(8'h00),
    .sd_byte_available(1'b0), .sd_ready_for_next_byte(1'b0), .sd_ready(1'b0)
  );

  // Sector buffer: registered read, written only by the stimulus block (preload).
  logic [7:0] mem_buf [0:SB-1];
  always @(posedge clk) buf_rdata <= mem_buf[buf_addr];

  // Observers: record every buffer write strobe and count done pulses.
  int         we_cnt = 0;
  int         done_cnt = 0;
  logic [8:0] we_addr [0:1023];
  logic [7:0] we_data [0:1023];
  always @(negedge clk) begin
    if (buf_we) begin
      we_addr[we_cnt % 1024] = buf_addr;
      we_data[we_cnt % 1024] = buf_wdata;
      we_cnt++;
    end
    if (done) done_cnt++;
  end

  int checks = 0;
  int failures = 0;
  int txn_no = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] exp_byte_addr(input logic [31:0] sector);
    logic [63:0] prod;
    prod = 64'(sector) * 64'd512;
    return prod[31:0];
  endfunction

  task automatic issue_cmd(input bit wr, input logic [31:0] sector);
    int  k;
    bit  b_ready;
    k = 0;
    while (!cmd_ready && k < 100) begin tick(1); k++; end
    check("cmd_ready_idle", cmd_ready, 1);
    b_ready    = cmd_ready_b;
    cmd_valid  = 1'b1;
    cmd_write  = wr;
    cmd_sector = sector;
    tick(1);
    cmd_valid  = 1'b0;
    cmd_write  = 1'($urandom);
    cmd_sector = $urandom;
    check("cmd_ready_busy", cmd_ready, 0);
    check("sd_address", sd_address, exp_byte_addr(sector));
    if (b_ready) check("sd_address_sdhc", sd_address_b, sector);
  endtask

  task automatic ctrl_start(input bit wr);
    int k;
    k = 0;
    while (!(sd_rd || sd_wr) && k < 50) begin tick(1); k++; end
    check("issue_strobe", {sd_rd, sd_wr}, wr ? 2'b01 : 2'b10);
    tick(2);
    sd_ready = 1'b0;
    tick(1);
    check("strobe_drop", {sd_rd, sd_wr}, 2'b00);
  endtask

  task automatic wait_done(input int budget, output logic e, output logic [1:0] c, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin tick(1); cyc++; end
    check("done_seen", done, 1);
    e = err;
    c = err_code;
  endtask

  task automatic post_done(input logic [1:0] exp_code);
    tick(1);
    check("done_one_cycle", done, 0);
    check("err_code_hold", err_code, exp_code);
    check("ready_after_done", cmd_ready, 1);
  endtask

  task automatic run_read(input logic [31:0] sector, input int n, input bit rnd);
    logic [7:0] sent [$];
    logic [7:0] d;
    logic       e;
    logic [1:0] c;
    int         base, exp_n, cyc;
    base = we_cnt;
    issue_cmd(1'b0, sector);
    ctrl_start(1'b0);
    for (int i = 0; i < n; i++) begin
      tick($urandom_range(1, 3));
      d = rnd ? 8'($urandom) : 8'(i);
      sd_dout = d;
      sd_byte_available = 1'b1;
      sent.push_back(d);
      tick(2);
      sd_byte_available = 1'b0;
    end
    tick(2);
    sd_ready = 1'b1;
    wait_done(50, e, c, cyc);
    exp_n = (n < SB) ? n : SB;
    check("rd_strobes", 64'(we_cnt - base), 64'(exp_n));
    check("rd_err", e, (n < SB) ? 1 : 0);
    check("rd_err_code", c, (n < SB) ? 2 : 0);
    for (int i = 0; i < exp_n; i++) begin
      check("rd_buf_addr", we_addr[(base + i) % 1024], 64'(i));
      check("rd_buf_data", we_data[(base + i) % 1024], sent[i]);
    end
    post_done((n < SB) ? 2'd2 : 2'd0);
    txn_no++;
    $display("txn %0d read  sector=0x%08h edges=%0d err_code=%0d", txn_no, sector, n, c);
  endtask

  task automatic run_write(input logic [31:0] sector, input int abort_at, input bit rnd);
    logic [7:0] got [$];
    logic       e;
    logic [1:0] c;
    int         cyc, done_base;
    for (int i = 0; i < SB; i++) mem_buf[i] = rnd ? 8'($urandom) : (8'hA5 ^ 8'(i));
    issue_cmd(1'b1, sector);
    ctrl_start(1'b1);
    for (int i = 0; i < SB; i++) begin
      sd_ready_for_next_byte = 1'b1;
      tick(3);
      if (i == abort_at) begin
        done_base = done_cnt;
        reset = 1'b1;
        sd_ready = 1'b1;
        sd_ready_for_next_byte = 1'b0;
        tick(1);
        check("rst_sd_wr", sd_wr, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        reset = 1'b0;
        tick(4);
        check("rst_no_done_pulse", 64'(done_cnt - done_base), 0);
        check("rst_idle_ready", cmd_ready, 1);
        txn_no++;
        $display("txn %0d write sector=0x%08h aborted by reset at byte %0d", txn_no, sector, i);
        return;
      end
      got.push_back(sd_din);
      sd_ready_for_next_byte = 1'b0;
      tick($urandom_range(2, 4));
    end
    tick(2);
    sd_ready = 1'b1;
    wait_done(50, e, c, cyc);
    check("wr_err", e, 0);
    check("wr_err_code", c, 0);
    for (int i = 0; i < SB; i++) check("wr_sd_din", got[i], mem_buf[i]);
    check("wr_din_hold_last", sd_din, mem_buf[SB-1]);
    post_done(2'd0);
    txn_no++;
    $display("txn %0d write sector=0x%08h bytes=%0d err_code=%0d", txn_no, sector, got.size(), c);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic       e;
    logic [1:0] c;
    int         cyc, k;
    logic [31:0] sec;

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sector = '0;
    sd_dout = '0; sd_byte_available = 1'b0; sd_ready_for_next_byte = 1'b0; sd_ready = 1'b1;
    for (int i = 0; i < SB; i++) mem_buf[i] = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_err_code", err_code, 0);
    check("reset_buf_addr", buf_addr, 0);
    check("reset_buf_we", buf_we, 0);
    check("reset_strobes", {sd_rd, sd_wr}, 0);
    check("reset_sd_address", sd_address, 0);
    check("reset_sd_din", sd_din, 0);

    run_read(32'd3, SB, 1'b0);
    run_write(32'd7, -1, 1'b0);
    run_read($urandom, 100, 1'b1);

    // No sd_ready at all: expect a timeout abort after TMO cycles.
    sd_ready = 1'b0;
    sec = $urandom;
    issue_cmd(1'b0, sec);
    wait_done(TMO + 50, e, c, cyc);
    check("tmo_cycles_in_range", (cyc >= TMO - 3 && cyc <= TMO + 3) ? 1 : 0, 1);
    check("tmo_err", e, 1);
    check("tmo_err_code", c, 1);
    check("tmo_strobes", {sd_rd, sd_wr}, 0);
    post_done(2'd1);
    sd_ready = 1'b1;
    txn_no++;
    $display("txn %0d read  sector=0x%08h timeout after %0d cycles err_code=%0d", txn_no, sec, cyc, c);

    run_read($urandom, SB + 1, 1'b1);
    run_write($urandom, 200, 1'b1);
    run_read($urandom, SB, 1'b1);

    // Reset while the read strobe is asserted must drop it on the next cycle.
    sec = $urandom;
    issue_cmd(1'b0, sec);
    k = 0;
    while (!sd_rd && k < 50) begin tick(1); k++; end
    check("issue_rd_before_reset", sd_rd, 1);
    reset = 1'b1;
    tick(1);
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_address", sd_address, 0);
    reset = 1'b0;
    tick(2);
    txn_no++;
    $display("txn %0d read  sector=0x%08h aborted by reset during issue", txn_no, sec);

    for (int t = 0; t < 4; t++) begin
      case ($urandom_range(0, 3))
        0:       run_read($urandom, SB, 1'b1);
        1:       run_read($urandom, $urandom_range(1, SB - 1), 1'b1);
        2:       run_read($urandom, SB + 1, 1'b1);
        default: run_write($urandom, -1, 1'b1);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_sector_sequencer.md
Name: sd_sector_sequencer

Overview:
Sequences whole-sector transfers through the existing sd_controller SPI engine. It accepts a read or write command for one 512-byte sector, drives the controller's rd/wr/address/din handshake, and streams bytes to or from an external 512x8 sector buffer. It reports completion or error. It sits between the application (display/loader logic) and sd_controller, replacing direct top-level wiring of rd/wr/address.

Parameters:
SDHC, 0, 0 = byte addressing (sd_address = sector<<9, truncated to 32 bits); 1 = block addressing (sd_address = sector)
TIMEOUT_CYCLES, 50000000, clk cycles without progress before the error abort (0.5 s at 100 MHz)
SECTOR_BYTES, 512, bytes per transfer; must be a power of two

Ports:
clk  in  1  100 MHz system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write sector, 0 = read sector
cmd_sector  in  32  sector number
done  out  1  one-cycle pulse at end of command (success or error)
err  out  1  valid with done; 1 = command failed
err_code  out  2  0 none, 1 timeout, 2 short transfer (sd_ready returned before SECTOR_BYTES bytes)
buf_addr  out  9  sector buffer byte index
buf_we  out  1  buffer write strobe (read commands)
buf_wdata  out  8  buffer write data
buf_rdata  in  8  buffer read data, 1-cycle latency from buf_addr
sd_rd  out  1  to sd_controller rd
sd_wr  out  1  to sd_controller wr
sd_address  out  32  to sd_controller address
sd_din  out  8  to sd_controller din
sd_dout  in  8  from sd_controller dout
sd_byte_available  in  1  from sd_controller, level
sd_ready_for_next_byte  in  1  from sd_controller, level
sd_ready  in  1  from sd_controller

Behaviour:
- Reset: state IDLE; sd_rd, sd_wr, done, err, buf_we = 0; err_code, buf_addr, sd_din, sd_address = 0; byte counter and timeout counter = 0. cmd_ready = 1 in the first cycle after reset is released. Reset mid-transfer drops sd_rd/sd_wr immediately. No done pulse is issued for an aborted command.
- sd_byte_available and sd_ready_for_next_byte are registered once. Edges are detected against the registered copy.
- IDLE: on accept, latch cmd_write and compute sd_address per SDHC; go to WAIT_READY; clear the byte counter.
- WAIT_READY: wait for sd_ready = 1. For a write, buf_addr = 0 is issued here so sd_din is loaded before ISSUE.
- ISSUE: assert sd_rd (read) or sd_wr (write). Hold it until sd_ready = 0, then deassert it in the same cycle and go to XFER.
- XFER_RD: on each rising edge of byte_available with count < SECTOR_BYTES, pulse buf_we for one cycle with buf_addr = count and buf_wdata = sd_dout, then increment count. Rising edges with count = SECTOR_BYTES are ignored.
- XFER_WR: sd_din holds byte[count] while ready_for_next_byte is high. On a falling edge of ready_for_next_byte: count++, buf_addr = count+1, and sd_din is loaded from buf_rdata one cycle later. After byte 511, sd_din holds its last value.
- In either XFER: sd_ready = 1 with count = SECTOR_BYTES means success, go to DONE. sd_ready = 1 with count < SECTOR_BYTES means err_code = 2, go to DONE.
- Timeout: the counter clears on state change and on each byte event. Reaching TIMEOUT_CYCLES in WAIT_READY, ISSUE or XFER sets err_code = 1, deasserts sd_rd/sd_wr and goes to DONE.
- DONE: pulse done for one cycle with err = (err_code != 0); err_code holds until the next accept; return to IDLE. Minimum accept-to-accept is 5 cycles.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Package sd_seq_pkg: state enum (IDLE, WAIT_READY, ISSUE, XFER_RD, XFER_WR, DONE), err_code constants (ERR_NONE, ERR_TIMEOUT, ERR_SHORT), SECTOR_BYTES_DEFAULT.
- One sub-module, sd_edge_det: registers a level input and outputs one-cycle rise/fall pulses. Instantiated twice.

Test Plan:
- Read sector 3, SDHC = 0, with a controller model supplying 512 bytes i&0xFF -> sd_address = 0x600; 512 buf_we pulses with addresses 0..511 and data = i&0xFF; done = 1, err = 0.
- Write sector 7, SDHC = 1, buffer preloaded with 0xA5^i -> sd_address = 7; the model captures 512 bytes equal to 0xA5^i in order; done, err = 0.
- Model returns sd_ready after 100 bytes on a read -> done with err = 1, err_code = 2; exactly 100 buf_we pulses.
- sd_ready held low for TIMEOUT_CYCLES (overridden to 1000) -> done at cycle ~1000, err_code = 1, sd_rd = 0.
- Model emits 513 byte_available edges -> only 512 buf_we pulses; success.
- Reset asserted during byte 200 of a write -> next cycle sd_wr = 0, no done pulse, cmd_ready = 1; a subsequent read completes normally.
